// File: rtl/cv32e40p_rf_wb_scheduler.sv
// Write-back scheduler: arbitrates NUM_REQ result producers onto the two register-file
// write ports (one cycle registered) and tracks outstanding destinations for hazard checks.
module cv32e40p_rf_wb_scheduler #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 3,
  parameter bit          FPU        = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]         issue_addr_i,
  output logic                          issue_ready_o,
  input  logic [3*ADDR_WIDTH-1:0]       chk_addr_i,
  output logic [2:0]                    hazard_o,
  output logic [ADDR_WIDTH-1:0]         waddr_a_o,
  output logic [DATA_WIDTH-1:0]         wdata_a_o,
  output logic                          we_a_o,
  output logic [ADDR_WIDTH-1:0]         waddr_b_o,
  output logic [DATA_WIDTH-1:0]         wdata_b_o,
  output logic                          we_b_o
);

  localparam int unsigned RRW  = $clog2(NUM_REQ);
  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  function automatic logic dropped(input logic [ADDR_WIDTH-1:0] a);
    return (a == '0) || (!FPU && a[ADDR_WIDTH-1]);
  endfunction

  logic [RRW-1:0]        rr_q, rr_d;
  logic [NREG-1:0]       pending_q, pending_d;
  logic                  we_a_q, we_b_q;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;

  logic [NUM_REQ-1:0]    grant;
  logic                  use_a, use_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [DATA_WIDTH-1:0] data_a, data_b;
  int unsigned           rr_start;

  always_comb begin
    grant    = '0;
    use_a    = 1'b0;
    use_b    = 1'b0;
    addr_a   = '0;
    addr_b   = '0;
    data_a   = '0;
    data_b   = '0;
    rr_d     = rr_q;
    rr_start = 32'(rr_q);
    if (req_valid_i[0]) begin
      grant[0] = 1'b1;
      use_b    = 1'b1;
      addr_b   = req_addr_i[0 +: ADDR_WIDTH];
      data_b   = req_data_i[0 +: DATA_WIDTH];
    end
    // Round-robin as two linear passes: requesters rr..N-1 first, then 1..rr-1.
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 1; i < NUM_REQ; i++) begin
        if (((pass == 0) == (i >= rr_start)) && req_valid_i[i] && !use_a &&
            !(use_b && req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == addr_b)) begin
          grant[i] = 1'b1;
          if (!use_b) begin
            use_b  = 1'b1;
            addr_b = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_b = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            use_a  = 1'b1;
            addr_a = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_a = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
          end
          rr_d = (i == NUM_REQ - 1) ? RRW'(1) : RRW'(i + 1);
        end
      end
    end
  end

  assign req_ready_o   = grant;
  assign issue_ready_o = !pending_q[issue_addr_i];

  always_comb begin
    pending_d = pending_q;
    if (use_a) pending_d[addr_a] = 1'b0;
    if (use_b) pending_d[addr_b] = 1'b0;
    // A new producer issued on the same edge as the old one's write keeps the bit set.
    if (issue_valid_i && issue_ready_o && !dropped(issue_addr_i))
      pending_d[issue_addr_i] = 1'b1;
  end

  logic [ADDR_WIDTH-1:0] chk_a;
  always_comb begin
    hazard_o = '0;
    chk_a    = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      chk_a       = chk_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      hazard_o[k] = pending_q[chk_a] && (chk_a != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_a_q <= '0;
      waddr_b_q <= '0;
      wdata_a_q <= '0;
      wdata_b_q <= '0;
      rr_q      <= RRW'(1);
      pending_q <= '0;
    end else begin
      we_a_q <= use_a && !dropped(addr_a);
      we_b_q <= use_b && !dropped(addr_b);
      if (use_a && !dropped(addr_a)) begin
        waddr_a_q <= addr_a;
        wdata_a_q <= data_a;
      end
      if (use_b && !dropped(addr_b)) begin
        waddr_b_q <= addr_b;
        wdata_b_q <= data_b;
      end
      rr_q      <= rr_d;
      pending_q <= pending_d;
    end
  end

  assign we_a_o    = we_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_a_o = waddr_a_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_a_o = wdata_a_q;
  assign wdata_b_o = wdata_b_q;

endmodule
